axis_mm_engine: RTL and testbench

//  Stream matrix-multiply engine on the AXI side of the user project, fed by the Wishbone-to-AXI bridge (0x301x_xxxx window).
//  AXI-Lite: control/status. AXI-Stream in: A then B, row-major, 2*N*N words. AXI-Stream out: C=A*B, row-major, N*N words.
//  One multiply-accumulate per cycle, driven by a single FSM.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_mac.sv | 34 +++
 rtl/axis_mm_engine.sv | 201 ++++++++++++++++++++
 tb/tb_axis_mm_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the stream matrix-multiply engine:
// FSM encoding, register offsets, ap_ctrl bit positions, default sizes.
package mm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_OUT
  } state_t;

  localparam int REG_CTRL = 'h00;
  localparam int REG_PERF = 'h10;

  localparam int B_START = 0;
  localparam int B_DONE  = 1;
  localparam int B_IDLE  = 2;
  localparam int B_ERR   = 3;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mm_mac.sv
// Registered signed multiply-accumulate; clr restarts the sum at zero,
// the accumulator wraps at DW bits.
module mm_mac
  import mm_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] prod;
  logic [DW-1:0] base;

  // Low DW bits of the signed product are all the wrapping sum needs.
  assign prod = $signed(a) * $signed(b);
  assign base = clr ? '0 : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + prod;
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/axis_mm_engine.sv
// AXI-Lite controlled stream matrix multiply C=A*B, one MAC per cycle.
// Optional cycle counter at 0x10 when MM_PERF_CNT_EN is defined.
module axis_mm_engine
  import mm_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = 12
) (
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  input  logic          awvalid,
  output logic          awready,
  input  logic [AW-1:0] awaddr,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  output logic          bvalid,
  input  logic          bready,
  input  logic          arvalid,
  output logic          arready,
  input  logic [AW-1:0] araddr,
  output logic          rvalid,
  input  logic          rready,
  output logic [DW-1:0] rdata,
  input  logic          ss_tvalid,
  output logic          ss_tready,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          sm_tvalid,
  input  logic          sm_tready,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tlast
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = $clog2(N * N);
  localparam int WC = $clog2(2 * N * N);
  localparam logic [IW-1:0] LASTI = IW'(N - 1);
  localparam logic [WC-1:0] LASTW = WC'(2 * N * N - 1);

  state_t        state, nxt;
  logic [IW-1:0] i, j, k;
  logic [WC-1:0] wcnt;
  logic [DW-1:0] a_m [N*N];
  logic [DW-1:0] b_m [N*N];
  logic [DW-1:0] acc, rd_val, perf;
  logic [XW-1:0] a_idx, b_idx, la_idx, lb_idx;
  logic          ap_start, ap_done, err;
  logic          aw_acc, ar_acc;
  logic          do_wr, start_wr, rd_clr;
  logic          beat, last_w, last_o;
  logic          out_hs, done_set, in_a;
  logic          unused_wdata;

  assign unused_wdata = ^wdata;

  assign beat     = (state == S_LOAD) && ss_tvalid;
  assign last_w   = (wcnt == LASTW);
  assign last_o   = (i == LASTI) && (j == LASTI);
  assign out_hs   = (state == S_OUT) && sm_tready;
  assign done_set = out_hs && last_o;
  assign in_a     = 32'(wcnt) < N * N;

  assign do_wr    = aw_acc && awvalid && wvalid;
  assign start_wr = do_wr && (awaddr == AW'(REG_CTRL))
                  && wdata[B_START] && (state == S_IDLE);
  assign rd_clr   = ar_acc && (araddr == AW'(REG_CTRL));

  assign awready   = aw_acc;
  assign wready    = aw_acc;
  assign arready   = ar_acc;
  assign ss_tready = (state == S_LOAD);
  assign sm_tvalid = (state == S_OUT);
  assign sm_tdata  = sm_tvalid ? acc : '0;
  assign sm_tlast  = sm_tvalid && last_o;

  always_comb begin
    a_idx  = XW'(32'(i) * N + 32'(k));
    b_idx  = XW'(32'(k) * N + 32'(j));
    la_idx = XW'(32'(wcnt));
    lb_idx = XW'(32'(wcnt) - N * N);
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (ap_start)         nxt = S_LOAD;
      S_LOAD: if (beat && last_w)   nxt = S_CALC;
      S_CALC: if (k == LASTI)       nxt = S_OUT;
      S_OUT:  if (out_hs)           nxt = last_o ? S_IDLE : S_CALC;
      default:                      nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      wcnt <= '0;
      i    <= '0;
      j    <= '0;
      k    <= '0;
    end else begin
      if (state == S_IDLE) begin
        wcnt <= '0;
        i    <= '0;
        j    <= '0;
        k    <= '0;
      end
      if (beat) wcnt <= wcnt + 1'b1;
      if (state == S_CALC) k <= (k == LASTI) ? '0 : k + 1'b1;
      if (out_hs) begin
        j <= (j == LASTI) ? '0 : j + 1'b1;
        if (j == LASTI) i <= (i == LASTI) ? '0 : i + 1'b1;
      end
    end
  end

  // Matrix storage survives reset; it is fully rewritten on every run.
  always_ff @(posedge axis_clk) begin
    if (beat) begin
      if (in_a) a_m[la_idx] <= ss_tdata;
      else      b_m[lb_idx] <= ss_tdata;
    end
  end

  mm_mac #(.DW(DW)) u_mac (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .clr   ((state == S_CALC) && (k == '0)),
    .en    (state == S_CALC),
    .a     (a_m[a_idx]),
    .b     (b_m[b_idx]),
    .acc   (acc)
  );

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      ap_start <= 1'b0;
      ap_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (start_wr) begin
        ap_start <= 1'b1;
        err      <= 1'b0;
      end else if (state == S_LOAD) begin
        ap_start <= 1'b0;
      end
      if (beat && (ss_tlast != last_w)) err <= 1'b1;
      if (done_set)    ap_done <= 1'b1;
      else if (rd_clr) ap_done <= 1'b0;
    end
  end

`ifdef MM_PERF_CNT_EN
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || start_wr) perf <= '0;
    else if ((state != S_IDLE) && (perf != '1)) perf <= perf + 1'b1;
  end
`else
  assign perf = '0;
`endif

  always_comb begin
    rd_val = '0;
    if (araddr == AW'(REG_CTRL)) begin
      rd_val[B_START] = ap_start;
      rd_val[B_DONE]  = ap_done | done_set;
      rd_val[B_IDLE]  = (state == S_IDLE);
      rd_val[B_ERR]   = err;
    end else if (araddr == AW'(REG_PERF)) begin
      rd_val = perf;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      aw_acc <= 1'b0;
      bvalid <= 1'b0;
      ar_acc <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      aw_acc <= awvalid && wvalid && !aw_acc && !bvalid;
      if (do_wr)       bvalid <= 1'b1;
      else if (bready) bvalid <= 1'b0;
      ar_acc <= arvalid && !ar_acc && !rvalid;
      if (ar_acc) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_mm_engine.sv
// Directed table-driven bench for axis_mm_engine (N=4, DW=32),
// plus hand-written reset, control and unmapped-register sequences.
module tb_axis_mm_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic        ss_tvalid, ss_tready, ss_tlast;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tready, sm_tlast;
  logic [31:0] sm_tdata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  axis_mm_engine #(.N(4), .DW(32), .AW(12)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .bvalid     (bvalid),
    .bready     (bready),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .ss_tvalid  (ss_tvalid),
    .ss_tready  (ss_tready),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .sm_tvalid  (sm_tvalid),
    .sm_tready  (sm_tready),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast)
  );

  typedef struct packed {
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic [15:0][31:0] c;
    logic              bp;
    logic              tl_bad;
    logic [4:0]        tl_at;
    logic              mid;
    logic              chk_perf;
  } case_t;

  case_t tv [7];

`ifdef MM_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd112;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic axi_write(input logic [11:0] ad,
                           input logic [31:0] d);
    bit hs = 0;
    int n = 0;
    awaddr  = ad;
    wdata   = d;
    awvalid = 1;
    wvalid  = 1;
    while (!hs && n < 50) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 0;
    wvalid  = 0;
    if (!hs) tmo("aw_handshake");
    bready = 1;
    hs = 0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = bvalid;
      @(posedge clk); #1; n++;
    end
    bready = 0;
    if (!hs) tmo("b_response");
  endtask

  task automatic axi_read(input  logic [11:0] ad,
                          output logic [31:0] d);
    bit hs = 0;
    int n = 0;
    d       = '0;
    araddr  = ad;
    arvalid = 1;
    while (!hs && n < 50) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 0;
    if (!hs) tmo("ar_handshake");
    rready = 1;
    hs = 0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = rvalid;
      if (hs) d = rdata;
      @(posedge clk); #1; n++;
    end
    rready = 0;
    if (!hs) tmo("r_data");
  endtask

  function automatic logic [31:0] word(input case_t t, input int x);
    return (x < 16) ? t.a[x] : t.b[x-16];
  endfunction

  function automatic logic last_of(input case_t t, input int x);
    return t.tl_bad ? (x == int'(t.tl_at)) : (x == 31);
  endfunction

  task automatic feed(input case_t t);
    int  x = 0;
    int  n = 0;
    bit  hs;
    while (x < 32 && n < 2000) begin
      @(negedge clk); hs = ss_tvalid && ss_tready;
      @(posedge clk); #1; n++;
      if (hs) x++;
      if (x < 32) begin
        ss_tdata  = word(t, x);
        ss_tlast  = last_of(t, x);
        ss_tvalid = t.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
    ss_tvalid = 0;
    ss_tlast  = 0;
    if (x < 32) tmo("feed");
  endtask

  task automatic collect(input case_t t);
    int          got   = 0;
    int          n     = 0;
    bit          stall = 0;
    logic [31:0] held  = '0;
    while (got < 16 && n < 4000) begin
      @(negedge clk);
      if (stall) chk("sm_hold", {sm_tvalid, sm_tdata}, {1'b1, held});
      stall = sm_tvalid && !sm_tready;
      held  = sm_tdata;
      if (sm_tvalid && sm_tready) begin
        chk($sformatf("c%0d", got), sm_tdata, t.c[got]);
        chk($sformatf("tlast%0d", got), sm_tlast, got == 15);
        got++;
      end
      @(posedge clk); #1; n++;
      sm_tready = t.bp ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
    sm_tready = 0;
    if (got < 16) tmo("collect");
  endtask

  task automatic run_case(input case_t t, input int id);
    logic [31:0] v;
    sm_tready = !t.bp;
    ss_tdata  = t.a[0];
    ss_tlast  = last_of(t, 0);
    ss_tvalid = 1;
    axi_write(12'h000, 32'h1);
    feed(t);
    if (t.mid) begin
      fork
        collect(t);
        axi_write(12'h000, 32'h1);
      join
    end else begin
      collect(t);
    end
    axi_read(12'h000, v);
    chk($sformatf("ctrl_done_run%0d", id), v, {28'h0, t.tl_bad, 3'b110});
    axi_read(12'h000, v);
    chk($sformatf("ctrl_clr_run%0d", id), v, {28'h0, t.tl_bad, 3'b100});
    if (t.chk_perf) begin
      axi_read(12'h010, v);
      chk($sformatf("perf_run%0d", id), v, PERF_EXP);
    end
  endtask

  logic [31:0] neg_row [4];

  initial begin
    logic [31:0] v;
    int          n;

    neg_row[0] = 32'hFFFF_FFE4;
    neg_row[1] = 32'hFFFF_FFE0;
    neg_row[2] = 32'hFFFF_FFDC;
    neg_row[3] = 32'hFFFF_FFD8;

    for (int c = 0; c < 7; c++) begin
      tv[c] = '0;
      for (int x = 0; x < 16; x++) begin
        tv[c].a[x] = (x / 4 == x % 4) ? 32'd1 : 32'd0;
        tv[c].b[x] = 32'(x + 1);
        tv[c].c[x] = 32'(x + 1);
      end
    end
    tv[0].chk_perf = 1;
    for (int x = 0; x < 16; x++) begin
      tv[1].a[x] = 32'h7FFF_FFFF;
      tv[1].b[x] = 32'd2;
      tv[1].c[x] = 32'hFFFF_FFF8;
      tv[2].a[x] = 32'(x + 1);
      tv[2].b[x] = (x / 4 == x % 4) ? 32'd1 : 32'd0;
      tv[3].a[x] = 32'hFFFF_FFFF;
      tv[3].c[x] = neg_row[x % 4];
    end
    tv[4].bp     = 1;
    tv[5].tl_bad = 1;
    tv[5].tl_at  = 5'd5;
    tv[6].mid    = 1;

    rst_n     = 0;
    awvalid   = 0; wvalid = 0; awaddr = '0; wdata = '0;
    bready    = 0; arvalid = 0; araddr = '0; rready = 0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0;
    sm_tready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    chk("rst_hs", {awready, wready, bvalid, arready, rvalid,
                   ss_tready, sm_tvalid, sm_tlast}, 8'h00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sm_tdata", sm_tdata, 32'h0);
    @(posedge clk); #1;
    axi_read(12'h000, v);
    chk("rst_ctrl", v, 32'h4);
    axi_read(12'h010, v);
    chk("rst_perf", v, 32'h0);

    axi_write(12'h004, 32'hFFFF_FFFF);
    axi_read(12'h004, v);
    chk("unmapped_04", v, 32'h0);
    axi_read(12'h008, v);
    chk("unmapped_08", v, 32'h0);
    axi_read(12'h000, v);
    chk("ctrl_after_unmapped", v, 32'h4);

    for (int c = 0; c < 7; c++) run_case(tv[c], c);

    // Abort a run while a result is waiting in OUT.
    ss_tdata  = tv[0].a[0];
    ss_tlast  = 0;
    ss_tvalid = 1;
    sm_tready = 0;
    axi_write(12'h000, 32'h1);
    feed(tv[0]);
    n = 0;
    while (!sm_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sm_tvalid) tmo("wait_out");
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("abort_sm_tvalid", sm_tvalid, 1'b0);
    @(posedge clk); #1;
    axi_read(12'h000, v);
    chk("abort_ctrl", v, 32'h4);
    run_case(tv[0], 7);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
